multicycle_seq: RTL and testbench
=================================

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles a memory request may wait for mem_ack before the sequencer halts (legal range 1..255).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_opcode  input  4  opcode field of the instruction register; valid from the DECODE cycle onward.
REQ-005 mem_ack  input  1  the shared instruction/data memory port has completed the current request this cycle.
REQ-006 mem_req  output  1  memory access request.
REQ-007 mem_we  output  1  write strobe, qualifies mem_req.
REQ-008 mem_addr_sel  output  1  address source: 0 = PC, 1 = ALU result.
REQ-009 ir_write  output  1  load the instruction register.
REQ-010 pc_write  output  1  advance the PC.
REQ-011 ctl_alusrc / ctl_aluop / ctl_regdst / ctl_regwrite / ctl_memtoreg  output  1/5/1/1/1  datapath controls.
REQ-012 state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-013 illegal  output  1  sticky flag: illegal opcode decoded.
REQ-014 timeout  output  1  sticky flag: memory request exceeded TIMEOUT.
REQ-015 instr_count  output  16  count of retired instructions.

Function
REQ-016 Decode table (op: aluop, alusrc, regdst, memtoreg): ADD 0000: 00010,0,1,0; ADDI 0001: 00010,1,0,0; SUB 0010: 01110,0,1,0; AND 0011: 00000,0,1,0; OR 0100: 00001,0,1,0; LW 1000: 00010,1,0,1; SW 1001: 00010,1,0,0; NOP 1111: no datapath activity; all other opcodes are illegal.
REQ-017 The opcode is latched internally at the end of DECODE; instr_opcode changes after DECODE have no effect on the instruction in flight.
REQ-018 All outputs are deterministic 0 in any state or cycle not listed as asserting them; no X values are driven.
REQ-019 IDLE: all strobes 0; unconditional transition to FETCH on the next cycle.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; hold until mem_ack; in the ack cycle, ir_write=1 and pc_write=1 for exactly that cycle; next state is DECODE.
REQ-021 DECODE: one cycle; illegal opcode -> HALT and set illegal; NOP -> FETCH and retire; otherwise -> EXEC.
REQ-022 EXEC: one cycle driving ctl_aluop and ctl_alusrc per REQ-016; LW/SW -> MEM, all others -> WB.
REQ-023 ctl_aluop and ctl_alusrc stay valid from EXEC through the end of MEM and WB for the same instruction.
REQ-024 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for SW; hold until mem_ack; on ack, LW -> WB, SW -> FETCH and retire.
REQ-025 WB: one cycle; ctl_regwrite=1 with ctl_regdst and ctl_memtoreg per REQ-016; next state is FETCH and the instruction retires.
REQ-026 Wait counter: cleared on entry to FETCH or MEM; increments on each cycle in FETCH or MEM without mem_ack.
REQ-027 When the wait counter equals TIMEOUT and mem_ack is low, the sequencer moves to HALT and sets timeout.
REQ-028 When mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins and no timeout occurs.
REQ-029 mem_ack in IDLE, DECODE, EXEC, WB or HALT is ignored.
REQ-030 HALT: all strobes 0, flags held; the sequencer leaves HALT only through reset.
REQ-031 instr_count increments by 1 on the cycle an instruction retires (per REQ-021/024/025) and wraps from 0xFFFF to 0x0000.

Reset
REQ-032 While rst_n=0, the sequencer is forced to IDLE immediately, regardless of clk.
REQ-033 While rst_n=0, every output is 0, including the illegal and timeout flags, instr_count, the wait counter and the latched opcode.
REQ-034 Reset asserted mid-access (FETCH or MEM) drops mem_req and mem_we asynchronously; a late mem_ack after reset release is ignored per REQ-029.
REQ-035 After rst_n deasserts, the first rising edge moves IDLE -> FETCH.

Verification
REQ-036 ADD (0000), mem_ack on the first FETCH cycle -> state sequence 0,1,2,3,5,1; ir_write and pc_write high in one cycle; ctl_regwrite high for one cycle with aluop=00010 and regdst=1; instr_count=1.
REQ-037 LW (1000), mem_ack 2 cycles late in MEM -> mem_req=1, mem_addr_sel=1 and mem_we=0 for 3 cycles; then WB with memtoreg=1 and regwrite=1; instr_count=1.
REQ-038 SW (1001) -> MEM drives mem_we=1; on ack, returns to FETCH with no regwrite cycle; instr_count increments.
REQ-039 Opcode 0101 -> DECODE -> HALT (state=6) with illegal=1; mem_req stays 0 forever despite mem_ack toggling; NOP 1111 instead returns to FETCH and counts.
REQ-040 TIMEOUT=4, mem_ack never asserted in FETCH -> HALT with timeout=1 after 5 FETCH cycles; rerun with ack on the 5th FETCH cycle -> DECODE and no timeout.
REQ-041 rst_n pulled low mid-MEM of an SW -> mem_req=0, mem_we=0, state=0 and counters 0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/writeback control
// with a bounded memory-wait timer, sticky error flags and a retire counter.
module multicycle_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  instr_opcode,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        ctl_alusrc,
    output logic [4:0]  ctl_aluop,
    output logic        ctl_regdst,
    output logic        ctl_regwrite,
    output logic        ctl_memtoreg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] instr_count
);
    // state  | meaning
    // IDLE   | post-reset, strobes quiet, goes to FETCH
    // FETCH  | instruction read from PC, waits for mem_ack
    // DECODE | opcode checked and latched
    // EXEC   | ALU controls driven
    // MEM    | data access at ALU address (LW/SW), waits for mem_ack
    // WB     | register file write
    // HALT   | illegal opcode or memory timeout; exit only by reset
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [3:0]  r_op;
    logic [7:0]  r_wait;
    logic        r_illegal;
    logic        r_timeout;
    logic [15:0] r_count;

    logic        w_legal;
    logic        w_in_wait;
    logic        w_expire;
    logic        w_enter_wait;
    logic        w_retire;
    logic        w_mem_op;
    logic [4:0]  w_aluop;
    logic        w_alusrc;
    logic        w_regdst;
    logic        w_memtoreg;

    always_comb begin
        w_legal = 1'b0;
        case (instr_opcode)
            OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR,
            OP_LW, OP_SW, OP_NOP: w_legal = 1'b1;
            default:              w_legal = 1'b0;
        endcase
    end

    // Datapath controls come from the latched opcode so late opcode changes cannot leak in.
    always_comb begin
        w_aluop    = 5'b00000;
        w_alusrc   = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        case (r_op)
            OP_ADD:  begin w_aluop = 5'b00010; w_regdst = 1'b1; end
            OP_ADDI: begin w_aluop = 5'b00010; w_alusrc = 1'b1; end
            OP_SUB:  begin w_aluop = 5'b01110; w_regdst = 1'b1; end
            OP_AND:  begin w_aluop = 5'b00000; w_regdst = 1'b1; end
            OP_OR:   begin w_aluop = 5'b00001; w_regdst = 1'b1; end
            OP_LW:   begin w_aluop = 5'b00010; w_alusrc = 1'b1; w_memtoreg = 1'b1; end
            OP_SW:   begin w_aluop = 5'b00010; w_alusrc = 1'b1; end
            default: ;
        endcase
    end

    assign w_mem_op  = (r_op == OP_LW) || (r_op == OP_SW);
    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEM);
    // An ack in the terminal cycle still completes the access.
    assign w_expire  = w_in_wait && !mem_ack && (r_wait == LP_TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (mem_ack) w_next = S_DECODE;
                      else if (w_expire) w_next = S_HALT;
            S_DECODE: if (!w_legal) w_next = S_HALT;
                      else if (instr_opcode == OP_NOP) w_next = S_FETCH;
                      else w_next = S_EXEC;
            S_EXEC:   w_next = w_mem_op ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) w_next = (r_op == OP_LW) ? S_WB : S_FETCH;
                      else if (w_expire) w_next = S_HALT;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_HALT;
        endcase
    end

    assign w_enter_wait = ((w_next == S_FETCH) || (w_next == S_MEM)) && (w_next != r_state);
    assign w_retire = ((r_state == S_DECODE) && (instr_opcode == OP_NOP))
                    || ((r_state == S_MEM) && mem_ack && (r_op == OP_SW))
                    || (r_state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= 4'b0000;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= instr_opcode;
            if (w_enter_wait) r_wait <= 8'd0;
            else if (w_in_wait && !mem_ack) r_wait <= r_wait + 8'd1;
            if ((r_state == S_DECODE) && !w_legal) r_illegal <= 1'b1;
            if (w_expire) r_timeout <= 1'b1;
            if (w_retire) r_count <= r_count + 16'd1;
        end
    end

    assign mem_req      = w_in_wait;
    assign mem_we       = (r_state == S_MEM) && (r_op == OP_SW);
    assign mem_addr_sel = (r_state == S_MEM);
    assign ir_write     = (r_state == S_FETCH) && mem_ack;
    assign pc_write     = (r_state == S_FETCH) && mem_ack;
    assign ctl_aluop    = ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) ? w_aluop : 5'b00000;
    assign ctl_alusrc   = ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) && w_alusrc;
    assign ctl_regwrite = (r_state == S_WB);
    assign ctl_regdst   = (r_state == S_WB) && w_regdst;
    assign ctl_memtoreg = (r_state == S_WB) && w_memtoreg;
    assign state        = r_state;
    assign illegal      = r_illegal;
    assign timeout      = r_timeout;
    assign instr_count  = r_count;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq built with TIMEOUT=4; inputs change at
// the falling edge and outputs are sampled 1 ns later.
module tb_multicycle_seq;
    logic        clk;
    logic        rst_n;
    logic [3:0]  instr_opcode;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic        ctl_alusrc, ctl_regdst, ctl_regwrite, ctl_memtoreg;
    logic [4:0]  ctl_aluop;
    logic [2:0]  state;
    logic        illegal, timeout;
    logic [15:0] instr_count;

    int total = 0;
    int bad   = 0;

    multicycle_seq #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .ctl_alusrc(ctl_alusrc),
        .ctl_aluop(ctl_aluop), .ctl_regdst(ctl_regdst), .ctl_regwrite(ctl_regwrite),
        .ctl_memtoreg(ctl_memtoreg), .state(state), .illegal(illegal),
        .timeout(timeout), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic ack);
        @(negedge clk);
        mem_ack = ack;
        #1;
    endtask

    // Leaves the sequencer in IDLE at a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        total++; if ({illegal, timeout} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {illegal, timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL reset_to_fetch: got %0d want 1", state); end
    endtask

    task automatic test_add();
        logic [2:0] exp_st [6];
        int irw, rw;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        irw = 0; rw = 0;
        instr_opcode = 4'b0000;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(i == 1);
            total++; if (state !== exp_st[i]) begin bad++; $display("FAIL add_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (ir_write && pc_write) irw++;
            if (ctl_regwrite) begin
                rw++;
                total++; if ({ctl_aluop, ctl_regdst} !== 6'b000101) begin bad++; $display("FAIL add_wb_ctl: got %b want 000101", {ctl_aluop, ctl_regdst}); end
            end
        end
        mem_ack = 1'b0;
        total++; if (irw !== 1) begin bad++; $display("FAIL add_irwrite_cycles: got %0d want 1", irw); end
        total++; if (rw !== 1) begin bad++; $display("FAIL add_regwrite_cycles: got %0d want 1", rw); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL add_count: got %0d want 1", instr_count); end
    endtask

    task automatic test_lw();
        instr_opcode = 4'b1000;
        apply_reset();
        step(1'b1);
        step(1'b0);
        step(1'b0);
        instr_opcode = 4'b0011;
        total++; if ({ctl_aluop, ctl_alusrc} !== 6'b000101) begin bad++; $display("FAIL lw_exec_ctl: got %b want 000101", {ctl_aluop, ctl_alusrc}); end
        for (int k = 0; k < 3; k++) begin
            step(k == 2);
            total++; if ({state, mem_req, mem_addr_sel, mem_we} !== 6'b100110) begin bad++; $display("FAIL lw_mem[%0d]: got %b want 100110", k, {state, mem_req, mem_addr_sel, mem_we}); end
        end
        step(1'b0);
        total++; if ({state, ctl_memtoreg, ctl_regwrite} !== 5'b10111) begin bad++; $display("FAIL lw_wb: got %b want 10111", {state, ctl_memtoreg, ctl_regwrite}); end
        total++; if ({ctl_aluop, ctl_alusrc} !== 6'b000101) begin bad++; $display("FAIL lw_wb_alu: got %b want 000101", {ctl_aluop, ctl_alusrc}); end
        step(1'b0);
        total++; if ({state, instr_count} !== {3'd1, 16'd1}) begin bad++; $display("FAIL lw_retire: got st=%0d cnt=%0d want st=1 cnt=1", state, instr_count); end
    endtask

    task automatic test_sw();
        instr_opcode = 4'b1001;
        apply_reset();
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        total++; if ({state, mem_req, mem_we, mem_addr_sel, ctl_regwrite} !== 7'b1001110) begin bad++; $display("FAIL sw_mem: got %b want 1001110", {state, mem_req, mem_we, mem_addr_sel, ctl_regwrite}); end
        step(1'b0);
        total++; if ({state, ctl_regwrite, mem_we} !== 5'b00100) begin bad++; $display("FAIL sw_return: got %b want 00100", {state, ctl_regwrite, mem_we}); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL sw_count: got %0d want 1", instr_count); end
    endtask

    task automatic test_illegal();
        instr_opcode = 4'b0101;
        apply_reset();
        step(1'b1);
        step(1'b0);
        total++; if ({state, illegal} !== 4'b0100) begin bad++; $display("FAIL ill_decode: got %b want 0100", {state, illegal}); end
        step(1'b0);
        total++; if ({state, illegal} !== 4'b1101) begin bad++; $display("FAIL ill_halt: got %b want 1101", {state, illegal}); end
        for (int k = 0; k < 6; k++) begin
            step(k[0]);
            total++; if ({state, mem_req, ir_write, illegal} !== 6'b110001) begin bad++; $display("FAIL ill_hold[%0d]: got %b want 110001", k, {state, mem_req, ir_write, illegal}); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_nop();
        instr_opcode = 4'b1111;
        apply_reset();
        step(1'b1);
        step(1'b0);
        step(1'b0);
        total++; if ({state, illegal, ctl_regwrite} !== 5'b00100) begin bad++; $display("FAIL nop_return: got %b want 00100", {state, illegal, ctl_regwrite}); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL nop_count: got %0d want 1", instr_count); end
    endtask

    task automatic test_timeout();
        instr_opcode = 4'b0000;
        apply_reset();
        for (int k = 0; k < 5; k++) step(1'b0);
        total++; if ({state, timeout} !== 4'b0010) begin bad++; $display("FAIL to_fifth_fetch: got %b want 0010", {state, timeout}); end
        step(1'b0);
        total++; if ({state, timeout, mem_req} !== 5'b11010) begin bad++; $display("FAIL to_halt: got %b want 11010", {state, timeout, mem_req}); end
        apply_reset();
        for (int k = 0; k < 4; k++) step(1'b0);
        step(1'b1);
        total++; if ({state, ir_write} !== 4'b0011) begin bad++; $display("FAIL to_ack_edge: got %b want 0011", {state, ir_write}); end
        step(1'b0);
        total++; if ({state, timeout} !== 4'b0100) begin bad++; $display("FAIL to_ack_wins: got %b want 0100", {state, timeout}); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops  [4];
        logic [6:0] exp  [4];
        ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};
        exp = '{7'b0001010, 7'b0111001, 7'b0000001, 7'b0000101};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            instr_opcode = ops[i];
            step(1'b1);
            step(1'b0);
            step(1'b0);
            instr_opcode = 4'b0101;
            total++; if ({ctl_aluop, ctl_alusrc} !== exp[i][6:1]) begin bad++; $display("FAIL b2b_exec[%0d]: got %b want %b", i, {ctl_aluop, ctl_alusrc}, exp[i][6:1]); end
            step(1'b0);
            total++; if ({ctl_regwrite, ctl_regdst, ctl_memtoreg} !== {1'b1, exp[i][0], 1'b0}) begin bad++; $display("FAIL b2b_wb[%0d]: got %b want %b", i, {ctl_regwrite, ctl_regdst, ctl_memtoreg}, {1'b1, exp[i][0], 1'b0}); end
        end
        step(1'b0);
        total++; if ({state, instr_count, illegal} !== {3'd1, 16'd4, 1'b0}) begin bad++; $display("FAIL b2b_count: got st=%0d cnt=%0d ill=%b want st=1 cnt=4 ill=0", state, instr_count, illegal); end
    endtask

    task automatic test_reset_mid_mem();
        instr_opcode = 4'b1001;
        apply_reset();
        step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        total++; if ({state, mem_we, instr_count} !== {3'd4, 1'b1, 16'd1}) begin bad++; $display("FAIL rst_mid_setup: got st=%0d we=%b cnt=%0d want st=4 we=1 cnt=1", state, mem_we, instr_count); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if ({state, mem_req, mem_we, instr_count} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin bad++; $display("FAIL rst_mid_async: got st=%0d req=%b we=%b cnt=%0d want 0 0 0 0", state, mem_req, mem_we, instr_count); end
        mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if ({state, ir_write} !== 4'b0000) begin bad++; $display("FAIL rst_late_ack: got %b want 0000", {state, ir_write}); end
        step(1'b0);
        total++; if ({state, instr_count} !== {3'd1, 16'd0}) begin bad++; $display("FAIL rst_after: got st=%0d cnt=%0d want st=1 cnt=0", state, instr_count); end
    endtask

    initial begin
        rst_n = 1'b1;
        mem_ack = 1'b0;
        instr_opcode = 4'b0000;
        #1 rst_n = 1'b0;
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_illegal();
        test_nop();
        test_timeout();
        test_back_to_back();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
